// File: rtl/dose_countdown_timer.sv
// Dose countdown timer: loads a clamped BCD hh:mm:ss value, counts it down once per second, and flags expiry.
// Optional macro DOSE_TIMER_ALARM_BLINK_EN makes the expired alarm blink at 1 s on / 1 s off.
module dose_countdown_timer #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic [23:0] loadTime,
  output logic [23:0] displayBits,
  output logic        running,
  output logic        alarm,
  output logic        secondPulse
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  // Value each digit takes when it borrows from zero, packed like the count.
  localparam logic [23:0] DIGIT_WRAP = 24'h995959;
  localparam logic [3:0]  CODE_START = 4'd3;

  typedef enum logic [1:0] {
    FSM_SETUP   = 2'd0,
    FSM_RUN     = 2'd1,
    FSM_EXPIRED = 2'd2
  } fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [23:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          running_q, running_d;
  logic          alarm_q, alarm_d;
  logic          pulse_q, pulse_d;

  logic [23:0]   dec_s;
  logic          presc_wrap_s;
  logic [PW-1:0] presc_next_s;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max_v);
    clamp_digit = (d > max_v) ? max_v : d;
  endfunction

  function automatic logic [23:0] clamp_time(input logic [23:0] t);
    logic [3:0] ht;
    logic [3:0] hu;
    ht = clamp_digit(t[23:20], 4'd1);
    hu = clamp_digit(t[19:16], 4'd9);
    if (ht == 4'd1) begin
      hu = clamp_digit(hu, 4'd2);
    end else begin
      hu = hu;
    end
    clamp_time = {ht, hu,
                  clamp_digit(t[15:12], 4'd5), clamp_digit(t[11:8], 4'd9),
                  clamp_digit(t[7:4], 4'd5),   clamp_digit(t[3:0], 4'd9)};
  endfunction

  function automatic logic [23:0] dec_time(input logic [23:0] t);
    logic [23:0] r;
    logic        borrow;
    r      = t;
    borrow = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = DIGIT_WRAP[i*4 +: 4];
          borrow      = 1'b1;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end else begin
        borrow = 1'b0;
      end
    end
    dec_time = r;
  endfunction

  // Next-state and next-output computation for the timer FSM.
  always_comb begin
    fsm_d        = fsm_q;
    count_d      = count_q;
    presc_d      = presc_q;
    running_d    = running_q;
    alarm_d      = alarm_q;
    pulse_d      = 1'b0;
    dec_s        = dec_time(count_q);
    presc_wrap_s = (presc_q == PRESC_LAST);
    presc_next_s = presc_wrap_s ? PRESC_ZERO : (presc_q + PRESC_ONE);

    // Codes 4..15 freeze the whole block; the strobe simply does not fire.
    if (state > CODE_START) begin
      pulse_d = 1'b0;
    end else begin
      case (fsm_q)
        FSM_SETUP: begin
          running_d = 1'b0;
          alarm_d   = 1'b0;
          presc_d   = PRESC_ZERO;
          if (state == CODE_START) begin
            fsm_d     = FSM_RUN;
            running_d = 1'b1;
          end else begin
            count_d = clamp_time(loadTime);
          end
        end
        FSM_RUN: begin
          if (state != CODE_START) begin
            fsm_d     = FSM_SETUP;
            running_d = 1'b0;
            alarm_d   = 1'b0;
          end else if (count_q == 24'h000000) begin
            fsm_d     = FSM_EXPIRED;
            presc_d   = presc_next_s;
            running_d = 1'b0;
            alarm_d   = 1'b1;
          end else if (presc_wrap_s) begin
            presc_d = PRESC_ZERO;
            count_d = dec_s;
            pulse_d = 1'b1;
            if (dec_s == 24'h000000) begin
              fsm_d     = FSM_EXPIRED;
              running_d = 1'b0;
              alarm_d   = 1'b1;
            end else begin
              running_d = 1'b1;
              alarm_d   = 1'b0;
            end
          end else begin
            presc_d   = presc_next_s;
            running_d = 1'b1;
            alarm_d   = 1'b0;
          end
        end
        FSM_EXPIRED: begin
          count_d   = 24'h000000;
          presc_d   = presc_next_s;
          running_d = 1'b0;
          if (state != CODE_START) begin
            fsm_d   = FSM_SETUP;
            alarm_d = 1'b0;
          end else begin
`ifdef DOSE_TIMER_ALARM_BLINK_EN
            alarm_d = presc_wrap_s ? ~alarm_q : alarm_q;
`else
            alarm_d = 1'b1;
`endif
          end
        end
        default: begin
          fsm_d     = FSM_SETUP;
          count_d   = 24'h000000;
          presc_d   = PRESC_ZERO;
          running_d = 1'b0;
          alarm_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= FSM_SETUP;
      count_q   <= 24'h000000;
      presc_q   <= PRESC_ZERO;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
      pulse_q   <= pulse_d;
    end
  end

  assign displayBits = count_q;
  assign running     = running_q;
  assign alarm       = alarm_q;
  assign secondPulse = pulse_q;

endmodule

// File: tb/tb_dose_countdown_timer.sv
// Self-checking bench for dose_countdown_timer: directed scenarios plus randomized traffic
// checked against a seconds-based reference model.
module tb_dose_countdown_timer;

  localparam int T = 4;
`ifdef DOSE_TIMER_ALARM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [3:0]  state;
  logic [23:0] loadTime;
  logic [23:0] displayBits;
  logic        running;
  logic        alarm;
  logic        secondPulse;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0 = setup, 1 = run, 2 = expired; time kept as plain seconds.
  int m_mode  = 0;
  int m_secs  = 0;
  int m_presc = 0;
  bit m_run   = 1'b0;
  bit m_alarm = 1'b0;
  bit m_pulse = 1'b0;

  dose_countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .state(state), .loadTime(loadTime),
    .displayBits(displayBits), .running(running), .alarm(alarm), .secondPulse(secondPulse)
  );

  always #5 clk = ~clk;

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int clamp_secs(logic [23:0] t);
    int ht, hu, mt, mu, st, su;
    ht = min_i(int'(t[23:20]), 1);
    hu = min_i(int'(t[19:16]), 9);
    if (ht == 1) hu = min_i(hu, 2);
    mt = min_i(int'(t[15:12]), 5);
    mu = min_i(int'(t[11:8]), 9);
    st = min_i(int'(t[7:4]), 5);
    su = min_i(int'(t[3:0]), 9);
    return (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  function automatic logic [23:0] to_bcd(int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] st, input logic [23:0] lt);
    bit wrap;
    wrap    = (m_presc == T - 1);
    m_pulse = 1'b0;
    if (r) begin
      m_mode = 0; m_secs = 0; m_presc = 0; m_run = 1'b0; m_alarm = 1'b0;
    end else if (st > 4'd3) begin
      m_mode = m_mode;
    end else if (m_mode == 0) begin
      if (st == 4'd3) begin
        m_mode = 1; m_presc = 0; m_run = 1'b1;
      end else begin
        m_secs = clamp_secs(lt);
      end
    end else if (m_mode == 1) begin
      if (st != 4'd3) begin
        m_mode = 0; m_run = 1'b0; m_alarm = 1'b0;
      end else if (m_secs == 0) begin
        m_mode = 2; m_run = 1'b0; m_alarm = 1'b1; m_presc = wrap ? 0 : m_presc + 1;
      end else if (wrap) begin
        m_presc = 0; m_secs = m_secs - 1; m_pulse = 1'b1;
        if (m_secs == 0) begin
          m_mode = 2; m_run = 1'b0; m_alarm = 1'b1;
        end
      end else begin
        m_presc = m_presc + 1;
      end
    end else begin
      m_presc = wrap ? 0 : m_presc + 1;
      if (st != 4'd3) begin
        m_mode = 0; m_alarm = 1'b0;
      end else if (BLINK && wrap) begin
        m_alarm = ~m_alarm;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(reset, state, loadTime);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; state = 4'd1; loadTime = 24'h123456;
    step(); step();
    n_cmp++;
    if ({displayBits, running, alarm, secondPulse} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h r%b a%b p%b, want 000000 r0 a0 p0", displayBits, running, alarm, secondPulse);
    end
    reset = 1'b0;
  endtask

  task automatic test_load();
    state = 4'd1; loadTime = 24'h125959;
    step();
    n_cmp++;
    if (displayBits !== 24'h125959 || running !== 1'b0 || alarm !== 1'b0) begin
      n_err++;
      $display("FAIL load: got %h r%b a%b, want 125959 r0 a0", displayBits, running, alarm);
    end
  endtask

  task automatic test_borrow_chain();
    logic [23:0] exp_d;
    bit          exp_p;
    loadTime = 24'h010000; state = 4'd1;
    step();
    state = 4'd3;
    for (int i = 0; i < 9; i++) begin
      step();
      exp_d = (i < 4) ? 24'h010000 : (i < 8) ? 24'h005959 : 24'h005958;
      exp_p = (i == 4) || (i == 8);
      n_cmp++;
      if (displayBits !== exp_d || secondPulse !== exp_p || running !== 1'b1) begin
        n_err++;
        $display("FAIL borrow_chain cyc %0d: got %h p%b r%b, want %h p%b r1", i, displayBits, secondPulse, running, exp_d, exp_p);
      end
    end
    state = 4'd1;
    step();
  endtask

  task automatic test_expiry();
    logic [23:0] exp_d;
    loadTime = 24'h000002; state = 4'd1;
    step();
    state = 4'd3;
    for (int i = 0; i < 28; i++) begin
      step();
      exp_d = (i < 4) ? 24'h000002 : (i < 8) ? 24'h000001 : 24'h000000;
      n_cmp++;
      if (displayBits !== exp_d || running !== (i < 8) || secondPulse !== (i == 4 || i == 8) ||
          (i == 8 && alarm !== 1'b1) || alarm !== m_alarm) begin
        n_err++;
        $display("FAIL expiry cyc %0d: got %h r%b a%b p%b, want %h r%b a%b p%b", i, displayBits, running, alarm,
                 secondPulse, exp_d, (i < 8), m_alarm, (i == 4 || i == 8));
      end
    end
    state = 4'd1;
    step();
  endtask

  task automatic test_clamp_and_zero_start();
    state = 4'd1; loadTime = 24'h1F7A6B;
    step();
    n_cmp++;
    if (displayBits !== 24'h125959) begin
      n_err++;
      $display("FAIL clamp: got %h, want 125959", displayBits);
    end
    loadTime = 24'h000000;
    step();
    state = 4'd3;
    step();
    n_cmp++;
    if (running !== 1'b1 || alarm !== 1'b0 || secondPulse !== 1'b0) begin
      n_err++;
      $display("FAIL zero_start_run: got r%b a%b p%b, want r1 a0 p0", running, alarm, secondPulse);
    end
    step();
    n_cmp++;
    if (running !== 1'b0 || alarm !== 1'b1 || secondPulse !== 1'b0 || displayBits !== 24'h000000) begin
      n_err++;
      $display("FAIL zero_start_alarm: got %h r%b a%b p%b, want 000000 r0 a1 p0", displayBits, running, alarm, secondPulse);
    end
    state = 4'd1;
    step();
    n_cmp++;
    if (alarm !== 1'b0 || running !== 1'b0) begin
      n_err++;
      $display("FAIL leave_expired: got r%b a%b, want r0 a0", running, alarm);
    end
  endtask

  task automatic test_reset_mid_run();
    state = 4'd1; loadTime = 24'h003000;
    step();
    state = 4'd3;
    step(); step();
    n_cmp++;
    if (displayBits !== 24'h003000 || running !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_run: got %h r%b, want 003000 r1", displayBits, running);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if ({displayBits, running, alarm, secondPulse} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_mid_run: got %h r%b a%b p%b, want all 0", displayBits, running, alarm, secondPulse);
    end
    reset = 1'b0; state = 4'd1;
    step();
    n_cmp++;
    if (displayBits !== 24'h003000 || running !== 1'b0) begin
      n_err++;
      $display("FAIL reload_after_reset: got %h r%b, want 003000 r0", displayBits, running);
    end
  endtask

  task automatic test_invalid_code();
    state = 4'd1; loadTime = 24'h000100;
    step();
    state = 4'd3;
    repeat (6) step();
    state = 4'd7;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (displayBits !== 24'h000059 || running !== 1'b1 || alarm !== 1'b0) begin
        n_err++;
        $display("FAIL invalid_freeze cyc %0d: got %h r%b a%b, want 000059 r1 a0", i, displayBits, running, alarm);
      end
    end
    state = 4'd0; loadTime = 24'h000321;
    step();
    n_cmp++;
    if (running !== 1'b0 || displayBits !== 24'h000059) begin
      n_err++;
      $display("FAIL return_setup: got %h r%b, want 000059 r0", displayBits, running);
    end
    step();
    n_cmp++;
    if (displayBits !== 24'h000321) begin
      n_err++;
      $display("FAIL reload_after_setup: got %h, want 000321", displayBits);
    end
  endtask

  task automatic test_random();
    int r;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 15) == 0) begin
        r = $urandom_range(0, 9);
        state = (r < 6) ? 4'd3 : (r == 6) ? 4'd1 : (r == 7) ? 4'd0 : (r == 8) ? 4'd2 : 4'($urandom_range(4, 15));
        loadTime = ($urandom_range(0, 1) == 1) ? 24'($urandom) : {16'h0000, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
      n_cmp++;
      if ({displayBits, running, alarm, secondPulse} !== {to_bcd(m_secs), m_run, m_alarm, m_pulse}) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h r%b a%b p%b, want %h r%b a%b p%b", cyc, displayBits, running, alarm,
                 secondPulse, to_bcd(m_secs), m_run, m_alarm, m_pulse);
      end
    end
    reset = 1'b0; state = 4'd1;
    step();
  endtask

`ifdef DOSE_TIMER_ALARM_BLINK_EN
  task automatic test_blink();
    state = 4'd1; loadTime = 24'h000001;
    step();
    state = 4'd3;
    repeat (5) step();
    for (int k = 0; k < 17; k++) begin
      if (k > 0) step();
      n_cmp++;
      if (alarm !== (((k / 4) % 2) == 0) || displayBits !== 24'h000000) begin
        n_err++;
        $display("FAIL blink k %0d: got a%b %h, want a%b 000000", k, alarm, displayBits, (((k / 4) % 2) == 0));
      end
    end
    state = 4'd2;
    step();
    n_cmp++;
    if (alarm !== 1'b0) begin
      n_err++;
      $display("FAIL blink_leave: got a%b, want a0", alarm);
    end
  endtask
`endif

  initial begin
    clk = 1'b0; reset = 1'b1; state = 4'd0; loadTime = 24'h000000;
    test_reset();
    test_load();
    test_borrow_chain();
    test_expiry();
    test_clamp_and_zero_start();
    test_reset_mid_run();
    test_invalid_code();
`ifdef DOSE_TIMER_ALARM_BLINK_EN
    test_blink();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
